// File: rtl/imm_gen_stage.sv
// Registered immediate generator for decode with a 2-entry skid buffer (M + K), 1-cycle latency.
// in_ready comes straight from the skid state register; IMM_CSR_ZIMM_EN enables the CSR zimm format.
module imm_gen_stage #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_SH = 3'd6;
`ifdef IMM_CSR_ZIMM_EN
  localparam logic [2:0] FMT_Z  = 3'd7;
`endif

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  typedef enum logic {ONE, TWO} state_t;

  state_t state_q, state_d;
  logic   m_valid, m_valid_d;
  entry_t m_q, k_q, dec;
  logic   accept, xfer, load_m, load_k, m_from_k;

  // All formats are first built as 32-bit values, then widened from bit 31.
  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    sx = {{(XLEN-31){v[31]}}, v[30:0]};
  endfunction

  always_comb begin
    dec         = '0;
    dec.instr   = in_instr;
    dec.pc      = in_pc;
    dec.fmt     = FMT_R;
    dec.illegal = 1'b0;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = sx({in_instr[31:12], 12'h000});
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        dec.imm = sx({{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0});
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        dec.imm = sx({{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0});
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = sx({{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]});
      end
      7'b0000011, 7'b1100111, 7'b0001111: begin
        dec.fmt = FMT_I;
        dec.imm = sx({{20{in_instr[31]}}, in_instr[31:20]});
      end
      7'b0010011: begin
        if (in_instr[13:12] == 2'b01) begin
          dec.fmt                = FMT_SH;
          dec.imm[SHAMT_W-1:0]   = in_instr[20 +: SHAMT_W];
        end else begin
          dec.fmt = FMT_I;
          dec.imm = sx({{20{in_instr[31]}}, in_instr[31:20]});
        end
      end
      7'b0110011: dec.fmt = FMT_R;
      7'b1110011: begin
`ifdef IMM_CSR_ZIMM_EN
        if (in_instr[14]) begin
          dec.fmt      = FMT_Z;
          dec.imm[4:0] = in_instr[19:15];
        end else begin
          dec.fmt = FMT_I;
          dec.imm = sx({{20{in_instr[31]}}, in_instr[31:20]});
        end
`else
        dec.fmt = FMT_I;
        dec.imm = sx({{20{in_instr[31]}}, in_instr[31:20]});
`endif
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  assign in_ready  = (state_q == ONE);
  assign out_valid = m_valid;
  assign accept    = in_valid & in_ready;
  assign xfer      = m_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid;
    load_m    = 1'b0;
    load_k    = 1'b0;
    m_from_k  = 1'b0;
    case (state_q)
      ONE: begin
        if (accept) begin
          if (!m_valid || out_ready) begin
            load_m    = 1'b1;
            m_valid_d = 1'b1;
          end else begin
            load_k  = 1'b1;
            state_d = TWO;
          end
        end else if (xfer) begin
          m_valid_d = 1'b0;
        end
      end
      TWO: begin
        if (xfer) begin
          m_from_k = 1'b1;
          state_d  = ONE;
        end
      end
      default: state_d = ONE;
    endcase
    // A redirect squashes everything held and any same-cycle accept.
    if (flush) begin
      state_d   = ONE;
      m_valid_d = 1'b0;
      load_m    = 1'b0;
      load_k    = 1'b0;
      m_from_k  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ONE;
      m_valid <= 1'b0;
      m_q     <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      m_valid <= m_valid_d;
      if (load_m)        m_q <= dec;
      else if (m_from_k) m_q <= k_q;
      if (load_k)        k_q <= dec;
    end
  end

  assign out_instr   = m_q.instr;
  assign out_pc      = m_q.pc;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomised scoreboard bench for imm_gen_stage (XLEN=32) plus directed decode, skid, flush and reset cases.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
  logic [2:0]  out_fmt;

  imm_gen_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decode built from the field layouts with plain arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] v;
    e.instr = ins; e.pc = pc; e.imm = 32'd0; e.fmt = 3'd0; e.ill = 1'b0;
    case (ins[6:0])
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = ins & 32'hFFFF_F000; end
      7'h6F: begin
        v = (((ins >> 12) & 32'hFF) << 12) + (((ins >> 20) & 32'h1) << 11) + (((ins >> 21) & 32'h3FF) << 1);
        if (ins[31]) v = v - 32'h0010_0000;
        e.fmt = 3'd5; e.imm = v;
      end
      7'h63: begin
        v = (((ins >> 7) & 32'h1) << 11) + (((ins >> 25) & 32'h3F) << 5) + (((ins >> 8) & 32'hF) << 1);
        if (ins[31]) v = v - 32'h1000;
        e.fmt = 3'd3; e.imm = v;
      end
      7'h23: begin
        v = ((ins >> 25) << 5) + ((ins >> 7) & 32'h1F);
        if (ins[31]) v = v - 32'h1000;
        e.fmt = 3'd2; e.imm = v;
      end
      7'h03, 7'h67, 7'h0F: begin e.fmt = 3'd1; e.imm = $signed(ins) >>> 20; end
      7'h13: begin
        if (((ins >> 12) & 32'h7) == 1 || ((ins >> 12) & 32'h7) == 5) begin
          e.fmt = 3'd6; e.imm = (ins >> 20) & 32'h1F;
        end else begin
          e.fmt = 3'd1; e.imm = $signed(ins) >>> 20;
        end
      end
      7'h33: e.fmt = 3'd0;
      7'h73: begin
`ifdef IMM_CSR_ZIMM_EN
        if (((ins >> 12) & 32'h4) != 0) begin e.fmt = 3'd7; e.imm = (ins >> 15) & 32'h1F; end
        else begin e.fmt = 3'd1; e.imm = $signed(ins) >>> 20; end
`else
        e.fmt = 3'd1; e.imm = $signed(ins) >>> 20;
`endif
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // One cycle: drive at negedge, compare settled outputs, advance the occupancy model.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl, output logic acc);
    exp_t e;
    logic m_rdy, m_vld;
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl;
    #1;
    m_rdy = (q.size() < 2);
    m_vld = (q.size() > 0);
    check("in_ready", in_ready, m_rdy);
    check("out_valid", out_valid, m_vld);
    if (m_vld && ordy) begin
      e = q.pop_front();
      n_out++;
      check("out_pc", out_pc, e.pc);
      check("out_instr", out_instr, e.instr);
      check("out_imm", out_imm, e.imm);
      check("out_fmt", out_fmt, e.fmt);
      check("out_illegal", out_illegal, e.ill);
    end
    acc = iv && m_rdy && !fl;
    if (fl) q.delete();
    else if (acc) q.push_back(ref_dec(ins, p));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    q.delete();
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_imm"}, out_imm, 0);
    check({tag, "_fmt"}, out_fmt, 0);
    check({tag, "_illegal"}, out_illegal, 0);
    check({tag, "_instr"}, out_instr, 0);
    check({tag, "_pc"}, out_pc, 0);
  endtask

  task automatic directed(input string tag, input logic [31:0] ins, input logic [31:0] imm,
                          input logic [2:0] fmt, input logic ill);
    logic a;
    step(1'b1, ins, 32'h8000_0000, 1'b0, 1'b0, a);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_imm"}, out_imm, imm);
    check({tag, "_fmt"}, out_fmt, fmt);
    check({tag, "_illegal"}, out_illegal, ill);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [12];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h03, 7'h67, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h7F};
    r = $urandom;
    if ($urandom_range(0, 12) == 12) return r;
    return {r[31:7], ops[$urandom_range(0, 11)]};
  endfunction

  initial begin
    logic        a;
    logic [31:0] cur_i, cur_p;
    logic [31:0] b2b [4];
    int          idx, start_out;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    do_reset("reset");

    directed("addi",  32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 1'b0);
    directed("sw",    32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2, 1'b0);
    directed("jal",   32'hFF9F_F06F, 32'hFFFF_FFF8, 3'd5, 1'b0);
    directed("srai",  32'h4030_D093, 32'h0000_0003, 3'd6, 1'b0);
    directed("lui",   32'h1234_50B7, 32'h1234_5000, 3'd4, 1'b0);
    directed("illeg", 32'hFFFF_FFFF, 32'h0000_0000, 3'd0, 1'b1);
`ifdef IMM_CSR_ZIMM_EN
    directed("csrrwi", 32'h3402_D073, 32'h0000_0005, 3'd7, 1'b0);
`else
    directed("csrrwi", 32'h3402_D073, 32'h0000_0340, 3'd1, 1'b0);
`endif

    // Back-to-back four with out_ready low for the first three cycles.
    b2b = '{32'h0010_0093, 32'hFE11_2E23, 32'h0000_0463, 32'h0000_00B3};
    idx = 0; start_out = n_out;
    for (int c = 0; c < 12; c++) begin
      step(idx < 4, b2b[idx % 4], 32'h100 + 32'(idx) * 4, c >= 3, 1'b0, a);
      if (c == 2) check("b2b_in_ready_drop", in_ready, 0);
      if (a) idx++;
    end
    check("b2b_all_out", n_out - start_out, 4);

    // Flush with M and K full and a new instr offered.
    step(1'b1, 32'h0000_0013, 32'h200, 1'b0, 1'b0, a);
    step(1'b1, 32'h0000_0113, 32'h204, 1'b0, 1'b0, a);
    step(1'b1, 32'h0000_0213, 32'h208, 1'b0, 1'b1, a);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    // Flush discarding a same-cycle accept into an empty stage.
    step(1'b1, 32'h0000_0313, 32'h20C, 1'b1, 1'b1, a);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);

    // Mid-operation reset with both entries held.
    step(1'b1, 32'hFFF0_0093, 32'h300, 1'b0, 1'b0, a);
    step(1'b1, 32'h1234_50B7, 32'h304, 1'b0, 1'b0, a);
    do_reset("midreset");

    cur_i = rand_instr(); cur_p = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 3) != 0, cur_i, cur_p, $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) == 0, a);
      if (a) begin
        cur_i = rand_instr();
        cur_p = cur_p + 4;
      end
    end
    for (int c = 0; c < 3; c++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
    check("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
